fifo_uart_tx: RTL and testbench

//  Read side of the 8-bit streaming FIFO. Pops one byte at a time using the FIFO's
//  RD_EN/EMPTY/BUFFER_OUT interface and transmits it on TX as an asynchronous serial

---
 rtl/fifo_uart_tx.sv | 138 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the streaming FIFO and sends each one as an
// asynchronous serial frame: start bit, 8 data bits LSB first, optional even
// parity bit, one stop bit.
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds the parity bit state).
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       FIFO_EMPTY,
  input  logic [7:0] FIFO_DATA,
  output logic       FIFO_RD_EN,
  output logic       TX,
  output logic       BUSY,
  output logic       TX_DONE
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StStart, StData, StParity, StStop
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  // Remembers whether FETCH really popped, so LOAD never latches stale data.
  logic             popped_q, popped_d;
  logic             wrap;

`ifdef FIFO_UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign wrap = (cnt_q == LastCnt);

  // State and datapath registers; async reset abandons any frame in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      popped_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      popped_q <= popped_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next state, bit timer and outputs decoded from the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    idx_d      = idx_q;
    shift_d    = shift_q;
    popped_d   = popped_q;
    FIFO_RD_EN = 1'b0;
    TX         = 1'b1;
    BUSY       = 1'b1;
    TX_DONE    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        BUSY = 1'b0;
        if (ENABLE && !FIFO_EMPTY) state_d = StFetch;
      end
      StFetch: begin
        FIFO_RD_EN = !FIFO_EMPTY;
        popped_d   = !FIFO_EMPTY;
        state_d    = StLoad;
      end
      StLoad: begin
        if (popped_q) begin
          shift_d = FIFO_DATA;
          idx_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^FIFO_DATA;
`endif
          state_d = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        TX    = 1'b0;
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) state_d = StData;
      end
      StData: begin
        TX    = shift_q[0];
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        TX    = parity_q;
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) state_d = StStop;
      end
`endif
      StStop: begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          TX_DONE = 1'b1;
          state_d = (ENABLE && !FIFO_EMPTY) ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a behavioural FIFO and checks
// every serial frame cycle by cycle against the byte stream pushed in.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ENABLE = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] buffer_out = 8'h00;
  logic       FIFO_RD_EN, TX, BUSY, TX_DONE;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENABLE     (ENABLE),
    .FIFO_EMPTY (fifo_empty),
    .FIFO_DATA  (buffer_out),
    .FIFO_RD_EN (FIFO_RD_EN),
    .TX         (TX),
    .BUSY       (BUSY),
    .TX_DONE    (TX_DONE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle", tag, got, exp);
    end
  endtask

  // Behavioural FIFO: pop on RD_EN, data appears on buffer_out the next cycle.
  logic [7:0] fq[$];
  logic       push_req = 1'b0;
  logic [7:0] push_data = 8'h00;
  always @(posedge CLK) begin
    if (FIFO_RD_EN && fq.size() > 0) buffer_out <= fq.pop_front();
    if (push_req) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: expected line level for cycle k of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int bn;
    bn = k / C;
    if (bn == 0) return 1'b0;
    if (bn <= 8) return b[bn-1];
    if (NBITS == 11 && bn == 9) return ^b;
    return 1'b1;
  endfunction

  // Frame monitor: spots start bits, then checks every cycle of the frame.
  logic [7:0] exp_q[$];
  logic [7:0] cur;
  bit   in_frame = 0, have_end = 0, prev_rd = 0, last_par = 0;
  int   k = 0, frames = 0, rd_pulses = 0, done_pulses = 0;
  int   start_cyc = 0, end_cyc = 0, last_len = 0;
  int   gaps[$];
  always @(negedge CLK) begin
    if (RST) begin
      in_frame = 0;
    end else begin
      if (!in_frame) begin
        if (TX === 1'b0) begin
          check("byte_expected", exp_q.size() > 0, 1);
          cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
          if (have_end) gaps.push_back(cyc - end_cyc - 1);
          start_cyc = cyc;
          k = 0;
          in_frame = 1;
        end else begin
          check("tx_idle", TX, 1);
          check("done_idle", TX_DONE, 0);
        end
      end
      if (in_frame) begin
        check("tx_bit", TX, exp_bit(cur, k));
        check("busy_frame", BUSY, 1);
        check("tx_done", TX_DONE, k == NBITS * C - 1);
        if (k == 9 * C + C / 2) last_par = TX;
        if (TX_DONE) begin
          done_pulses++;
          last_len = cyc - start_cyc + 1;
        end
        if (k == NBITS * C - 1) begin
          in_frame = 0;
          end_cyc  = cyc;
          have_end = 1;
          frames++;
        end else begin
          k++;
        end
      end
    end
    if (FIFO_RD_EN) begin
      rd_pulses++;
      check("rd_width", prev_rd, 0);
    end
    prev_rd = FIFO_RD_EN;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int push_cyc = 0;
  task automatic push(input logic [7:0] b);
    @(negedge CLK);
    push_req  = 1'b1;
    push_data = b;
    exp_q.push_back(b);
    @(posedge CLK);
    #1;
    push_req = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while (!(in_frame && k >= pos) && n < 400) begin tick(); n++; end
    if (n >= 400) check("timeout_pos", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(fq.size() == 0 && !in_frame && !BUSY && !push_req) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("timeout_drain", 0, 1);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while (!(!in_frame && !BUSY) && n < 400) begin tick(); n++; end
    if (n >= 400) check("timeout_quiet", 0, 1);
  endtask

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int rd0, fr0, dn0, nrand;
  initial begin
    #1;
    check("rst_tx", TX, 1);
    check("rst_busy", BUSY, 0);
    check("rst_rd", FIFO_RD_EN, 0);
    check("rst_done", TX_DONE, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    ENABLE = 1'b1;
    tick();

    // 1: reset mid-DATA drops the frame at once; the next byte goes out whole.
    push(8'h5A);
    wait_pos(2 * C + 1);
    RST = 1'b1;
    #1;
    check("rst_mid_tx", TX, 1);
    check("rst_mid_busy", BUSY, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    fr0 = frames;
    push(8'h3C);
    wait_drain();
    check("after_rst_frames", frames - fr0, 1);

    // 2: single 0xA5 frame, latency and length.
    rd0 = rd_pulses; fr0 = frames; dn0 = done_pulses;
    push(8'hA5);
    wait_drain();
    check("a5_latency", start_cyc - push_cyc, 3);
    check("a5_rd", rd_pulses - rd0, 1);
    check("a5_frames", frames - fr0, 1);
    check("a5_done", done_pulses - dn0, 1);
    check("a5_len", last_len, NBITS * C);
    check("a5_busy_after", BUSY, 0);

    // 3: three back-to-back frames with a 2-cycle gap each.
    have_end = 0; gaps.delete(); rd0 = rd_pulses;
    push(8'h00); push(8'hFF); push(8'h81);
    wait_drain();
    check("b2b_rd", rd_pulses - rd0, 3);
    check("b2b_ngaps", gaps.size(), 2);
    foreach (gaps[i]) check("b2b_gap", gaps[i], 2);
    check("b2b_empty", fifo_empty, 1);

    // 4: ENABLE low holds off, dropping it mid-frame stops after that frame.
    ENABLE = 1'b0;
    rd0 = rd_pulses; fr0 = frames;
    push(8'h12); push(8'h34);
    repeat (30) tick();
    check("dis_no_rd", rd_pulses - rd0, 0);
    check("dis_tx", TX, 1);
    ENABLE = 1'b1;
    wait_pos(0);
    ENABLE = 1'b0;
    wait_quiet();
    repeat (20) tick();
    check("dis_frames", frames - fr0, 1);
    check("dis_left", fq.size(), 1);
    check("dis_rd", rd_pulses - rd0, 1);
    ENABLE = 1'b1;
    wait_drain();

    // 6: push landing in the stop bit of the last queued byte.
    have_end = 0; gaps.delete();
    push(8'h6E);
    wait_pos((NBITS - 1) * C + 1);
    push(8'h91);
    wait_drain();
    check("stop_push_ngaps", gaps.size(), 1);
    if (gaps.size() > 0) check("stop_push_gap", gaps[0], 2);

`ifdef FIFO_UART_TX_PARITY_EN
    // 5: parity bit value and 44-cycle frame.
    push(8'h07);
    wait_drain();
    check("par_07", last_par, 1);
    check("par_len", last_len, 44);
    push(8'h03);
    wait_drain();
    check("par_03", last_par, 0);
`endif

    // Random traffic, every frame checked by the monitor.
    rd0 = rd_pulses; fr0 = frames; nrand = 24;
    for (int i = 0; i < nrand; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 50)) tick();
    end
    wait_drain();
    check("rand_rd", rd_pulses - rd0, nrand);
    check("rand_frames", frames - fr0, nrand);
    check("rand_exp_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
